// File: rtl/stack_ctrl_if.sv
// Push/pop request, SP and data-memory bus bundle between the control unit and stack_ctrl.
// slave is the stack_ctrl side, master the control-unit/memory side.
interface stack_ctrl_if;
  logic        push_req;
  logic        pop_req;
  logic [15:0] push_data;
  logic [15:0] sp_in;
  logic        sp_inc;
  logic        sp_dec;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [15:0] pop_data;

  modport slave (
    input  push_req, pop_req, push_data, sp_in, mem_rdata,
    output sp_inc, sp_dec, mem_addr, mem_wdata, mem_we, mem_re,
           busy, done, err, pop_data
  );

  modport master (
    output push_req, pop_req, push_data, sp_in, mem_rdata,
    input  sp_inc, sp_dec, mem_addr, mem_wdata, mem_we, mem_re,
           busy, done, err, pop_data
  );
endinterface

// File: rtl/stack_ctrl.sv
// Push/pop sequencer for an empty-descending stack in front of the SP register.
// state       | meaning
// st_idle     | sample push_req/pop_req, classify against sp_in
// st_push_wr  | write latched word at sp_in, strobe sp_dec
// st_pop_rd   | read at sp_in+1, strobe sp_inc
// st_pop_wait | count down read latency, capture mem_rdata on zero
// st_done     | one-cycle done pulse with err
module stack_ctrl #(
  parameter logic [15:0] STACK_TOP   = 16'h01FF,
  parameter logic [15:0] STACK_LIMIT = 16'h0100,
  parameter int          RD_LAT      = 1
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    st_idle,
    st_push_wr,
    st_pop_rd,
    st_pop_wait,
    st_done
  } state_t;

  localparam logic [15:0] SP_FULL   = STACK_LIMIT - 16'd1;
  localparam logic [1:0]  WAIT_INIT = 2'(RD_LAT - 1);

  state_t      state, state_nxt;
  logic [1:0]  err_q, err_nxt;
  logic [1:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] pop_q;

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      st_idle: begin
        if (bus.push_req && bus.pop_req) begin
          state_nxt = st_done;
          err_nxt   = 2'b11;
        end else if (bus.push_req) begin
          if (bus.sp_in == SP_FULL) begin
            state_nxt = st_done;
            err_nxt   = 2'b01;
          end else begin
            state_nxt = st_push_wr;
            err_nxt   = 2'b00;
          end
        end else if (bus.pop_req) begin
          if (bus.sp_in == STACK_TOP) begin
            state_nxt = st_done;
            err_nxt   = 2'b10;
          end else begin
            state_nxt = st_pop_rd;
            err_nxt   = 2'b00;
          end
        end
      end
      st_push_wr:  state_nxt = st_done;
      st_pop_rd:   state_nxt = st_pop_wait;
      st_pop_wait: if (cnt == 2'd0) state_nxt = st_done;
      st_done:     state_nxt = st_idle;
      default:     state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= st_idle;
      err_q   <= 2'b00;
      cnt     <= 2'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      pop_q   <= 16'h0000;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      // address and data are registered at acceptance so the access cycle sees stable values
      if (state == st_idle && state_nxt == st_push_wr) begin
        addr_q  <= bus.sp_in;
        wdata_q <= bus.push_data;
      end
      if (state == st_idle && state_nxt == st_pop_rd)
        addr_q <= bus.sp_in + 16'd1;
      if (state == st_pop_rd)
        cnt <= WAIT_INIT;
      if (state == st_pop_wait) begin
        if (cnt == 2'd0) pop_q <= bus.mem_rdata;
        else             cnt   <= cnt - 2'd1;
      end
    end
  end

  assign bus.mem_we    = (state == st_push_wr);
  assign bus.sp_dec    = (state == st_push_wr);
  assign bus.mem_re    = (state == st_pop_rd);
  assign bus.sp_inc    = (state == st_pop_rd);
  assign bus.busy      = (state != st_idle);
  assign bus.done      = (state == st_done);
  assign bus.err       = (state == st_done) ? err_q : 2'b00;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.pop_data  = pop_q;

endmodule
